lb_row_dma_sched: RTL and testbench

- Per-frame scheduler that feeds the 4-line-buffer image controller from a memory-mapped DMA engine, one image row per DMA transfer.
- Primes the 4 line buffers with 4 rows, then issues one new row per line-buffer interrupt (one output row consumed, one buffer freed).
- Signals frame completion once all convolution output rows have been drained.
- Sits between the CPU-facing register block and the DMA read channel.

---
 rtl/lb_row_dma_sched_pkg.sv | 23 ++
 rtl/lb_row_dma_sched_credit.sv | 45 ++++
 rtl/lb_row_dma_sched.sv | 151 +++++++++++++++
 tb/tb_lb_row_dma_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_row_dma_sched_pkg.sv
// Shared types and default geometry for the line-buffer row DMA scheduler.
package lb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_CREDIT,
    DRAIN
  } state_t;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_NUM_LB     = 4;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CRED_W = cnt_w(DEF_NUM_LB);

endpackage

// File: rtl/lb_row_dma_sched_credit.sv
// Saturating up/down credit counter with load and an overflow flag.
module lb_credit_cnt
  import lb_sched_pkg::*;
#(
  parameter int W   = CRED_W,
  parameter int MAX = DEF_NUM_LB
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX_V) ? v : v + W'(1);
  endfunction

  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
    return (v == '0) ? v : v - W'(1);
  endfunction

  // Overflow only when an increment is not cancelled by a same-cycle decrement.
  always_comb begin
    ovf = inc & ~dec & (cnt == MAX_V);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= MAX_V;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !dec) begin
      cnt <= sat_inc(cnt);
    end else if (dec && !inc) begin
      cnt <= sat_dec(cnt);
    end
  end

endmodule

// File: rtl/lb_row_dma_sched.sv
// Per-frame row DMA scheduler feeding the 4-line-buffer image controller.
// Optional cycle/stall counters are built when LB_SCHED_PERF_EN is defined.
module lb_row_dma_sched
  import lb_sched_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int NUM_LB     = DEF_NUM_LB,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_frame_base,
  input  logic [15:0]       i_stride,
  output logic              o_dma_req,
  output logic [ADDR_W-1:0] o_dma_addr,
  output logic [15:0]       o_dma_len,
  input  logic              i_dma_ack,
  input  logic              i_lb_intr,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err
`ifdef LB_SCHED_PERF_EN
  ,
  output logic [31:0]       o_frame_cycles,
  output logic [31:0]       o_stall_cycles
`else
`endif
);

  localparam int CW = cnt_w(NUM_LB);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [RW-1:0] ROWS_ALL  = RW'(IMG_HEIGHT);
  // The 3x3 window yields two fewer output rows than input rows.
  localparam logic [RW-1:0] INTR_LAST = RW'(IMG_HEIGHT - 2);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row_off;
  logic [15:0]       stride;
  logic [RW-1:0]     rows_issued;
  logic [RW-1:0]     intr_cnt;
  logic [CW-1:0]     credits;
  logic              start_acc, ack_acc, intr_acc;
  logic              issue_go, done, cred_ovf, err_set;

  always_comb begin
    start_acc = i_start & (state == IDLE);
    ack_acc   = i_dma_ack & (state == WAIT_ACK);
    intr_acc  = i_lb_intr & (state != IDLE);
    issue_go  = (credits != '0) && (rows_issued < ROWS_ALL);
    done      = (state == DRAIN) && (intr_cnt == INTR_LAST);
    err_set   = (i_lb_intr & (state == IDLE)) | cred_ovf
              | (i_dma_ack & (state != WAIT_ACK));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (i_start) state_nxt = ISSUE;
      ISSUE:       state_nxt = issue_go ? WAIT_ACK : WAIT_CREDIT;
      WAIT_ACK:    if (i_dma_ack) state_nxt = ISSUE;
      WAIT_CREDIT: begin
        if (rows_issued == ROWS_ALL) state_nxt = DRAIN;
        else if (issue_go)           state_nxt = ISSUE;
      end
      DRAIN:       if (done) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    o_busy       = (state != IDLE) & ~done;
    o_frame_done = done;
    o_dma_len    = 16'(IMG_WIDTH);
  end

  // Row offset accumulates stride per accepted row instead of multiplying.
  always_ff @(posedge i_clk) begin
    if (start_acc) begin
      base    <= i_frame_base;
      stride  <= i_stride;
      row_off <= '0;
    end else if (ack_acc) begin
      row_off <= row_off + ADDR_W'(stride);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dma_req   <= 1'b0;
      o_dma_addr  <= '0;
      rows_issued <= '0;
      intr_cnt    <= '0;
      o_err       <= 1'b0;
    end else begin
      if (state == ISSUE && issue_go) begin
        o_dma_req  <= 1'b1;
        o_dma_addr <= base + row_off;
      end else if (ack_acc) begin
        o_dma_req  <= 1'b0;
      end
      if (start_acc) begin
        rows_issued <= '0;
        intr_cnt    <= '0;
      end else begin
        if (ack_acc)  rows_issued <= rows_issued + RW'(1);
        if (intr_acc) intr_cnt    <= intr_cnt + RW'(1);
      end
      o_err <= (o_err & ~start_acc) | err_set;
    end
  end

  lb_credit_cnt #(
    .W   (CW),
    .MAX (NUM_LB)
  ) u_credit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (start_acc),
    .load_val (CW'(NUM_LB)),
    .inc      (intr_acc),
    .dec      (ack_acc),
    .cnt      (credits),
    .ovf      (cred_ovf)
  );

`ifdef LB_SCHED_PERF_EN
  // The accepting cycle counts as the first frame cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cycles <= '0;
      o_stall_cycles <= '0;
    end else if (start_acc) begin
      o_frame_cycles <= 32'd1;
      o_stall_cycles <= '0;
    end else begin
      if (state != IDLE)        o_frame_cycles <= o_frame_cycles + 32'd1;
      if (state == WAIT_CREDIT) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_lb_row_dma_sched.sv
// Directed bench for lb_row_dma_sched at default geometry (512x512, 4 buffers).
module tb_lb_row_dma_sched;

  localparam int H = 512;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_frame_base;
  logic [15:0] i_stride;
  logic        o_dma_req;
  logic [31:0] o_dma_addr;
  logic [15:0] o_dma_len;
  logic        i_dma_ack;
  logic        i_lb_intr;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_err;

  int nvec     = 0;
  int nmis     = 0;
  int done_cnt = 0;
  int req_cnt  = 0;

  always #5 i_clk = ~i_clk;

  lb_row_dma_sched dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_frame_base (i_frame_base),
    .i_stride     (i_stride),
    .o_dma_req    (o_dma_req),
    .o_dma_addr   (o_dma_addr),
    .o_dma_len    (o_dma_len),
    .i_dma_ack    (i_dma_ack),
    .i_lb_intr    (i_lb_intr),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  always @(negedge i_clk) begin
    if (o_frame_done)          done_cnt <= done_cnt + 1;
    if (o_dma_req && i_dma_ack) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_intr();
    i_lb_intr = 1'b1;
    tick();
    i_lb_intr = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [15:0] s);
    i_frame_base = b;
    i_stride     = s;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!o_dma_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {63'd0, o_dma_req}, 64'd1);
  endtask

  task automatic serve(input int dly, output logic [31:0] a, output int hold_bad);
    wait_req();
    a        = o_dma_addr;
    hold_bad = 0;
    repeat (dly) begin
      tick();
      if (!o_dma_req || o_dma_addr != a) hold_bad++;
    end
    i_dma_ack = 1'b1;
    tick();
    i_dma_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int hb, addr_bad, hold_tot, req_hi;

    i_rst = 1'b1; i_start = 1'b0; i_dma_ack = 1'b0; i_lb_intr = 1'b0;
    i_frame_base = '0; i_stride = '0;
    tick(); tick();
    chk("rst_req",   64'(o_dma_req),    64'd0);
    chk("rst_addr",  64'(o_dma_addr),   64'd0);
    chk("rst_len",   64'(o_dma_len),    64'd512);
    chk("rst_busy",  64'(o_busy),       64'd0);
    chk("rst_done",  64'(o_frame_done), 64'd0);
    chk("rst_err",   64'(o_err),        64'd0);
    chk("rst_cred",  64'(dut.credits),  64'd4);
    i_rst = 1'b0;
    tick();

    // Priming: four back-to-back rows with immediate ack
    start_frame(32'h1000_0000, 16'd512);
    chk("start_busy", 64'(o_busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      serve(0, a, hb);
      chk("prime_addr", 64'(a), 64'(32'h1000_0000 + 32'(k) * 32'd512));
    end
    chk("prime_len", 64'(o_dma_len), 64'd512);
    req_hi = 0;
    repeat (10) begin
      tick();
      if (o_dma_req) req_hi++;
    end
    chk("prime_stall", 64'(req_hi), 64'd0);
    chk("prime_cred", 64'(dut.credits), 64'd0);

    // Steady state: second intr arrives while the row is outstanding
    pulse_intr();
    wait_req();
    chk("steady_addr", 64'(o_dma_addr), 64'h1000_0800);
    pulse_intr();
    chk("steady_hold", 64'(o_dma_req), 64'd1);
    i_dma_ack = 1'b1; tick(); i_dma_ack = 1'b0;
    chk("steady_cred", 64'(dut.credits), 64'd1);
    chk("steady_gap", 64'(o_dma_req), 64'd0);
    tick();
    chk("steady_reissue", 64'(o_dma_req), 64'd1);
    chk("steady_addr2", 64'(o_dma_addr), 64'h1000_0A00);
    i_dma_ack = 1'b1; tick(); i_dma_ack = 1'b0;

    // Simultaneous ack and intr
    pulse_intr();
    wait_req();
    chk("sim_addr", 64'(o_dma_addr), 64'h1000_0C00);
    chk("sim_cred_pre", 64'(dut.credits), 64'd1);
    i_dma_ack = 1'b1; i_lb_intr = 1'b1;
    tick();
    i_dma_ack = 1'b0; i_lb_intr = 1'b0;
    chk("sim_cred", 64'(dut.credits), 64'd1);
    chk("sim_rows", 64'(dut.rows_issued), 64'd7);
    chk("sim_intr", 64'(dut.intr_cnt), 64'd4);
    serve(0, a, hb);
    chk("row7_addr", 64'(a), 64'h1000_0E00);

    // Remainder of the frame with random ack latency
    addr_bad = 0; hold_tot = 0;
    for (int k = 8; k < H; k++) begin
      pulse_intr();
      serve(int'($urandom_range(0, 5)), a, hb);
      hold_tot += hb;
      if (a != 32'h1000_0000 + 32'(k) * 32'd512) addr_bad++;
    end
    chk("frame_addrs", 64'(addr_bad), 64'd0);
    chk("frame_hold",  64'(hold_tot), 64'd0);
    chk("last_addr",   64'(a), 64'h1003_FE00);
    chk("rows_all",    64'(dut.rows_issued), 64'd512);
    chk("req_count",   64'(req_cnt), 64'd512);
    repeat (3) tick();
    chk("drain_busy",   64'(o_busy), 64'd1);
    chk("drain_nodone", 64'(done_cnt), 64'd0);
    pulse_intr();
    repeat (3) tick();
    chk("i509_nodone", 64'(done_cnt), 64'd0);
    chk("i509_busy",   64'(o_busy), 64'd1);
    i_lb_intr = 1'b1; tick(); i_lb_intr = 1'b0;
    chk("done_pulse", 64'(o_frame_done), 64'd1);
    chk("done_busy",  64'(o_busy), 64'd0);
    tick();
    chk("done_clear", 64'(o_frame_done), 64'd0);
    chk("idle_busy",  64'(o_busy), 64'd0);
    chk("done_once",  64'(done_cnt), 64'd1);
    chk("frame_err",  64'(o_err), 64'd0);

    // Errors: intr in IDLE, then credit overflow
    pulse_intr();
    chk("idle_intr_err", 64'(o_err), 64'd1);
    repeat (3) tick();
    chk("err_sticky",    64'(o_err), 64'd1);
    chk("idle_intr_cnt", 64'(dut.intr_cnt), 64'd510);
    start_frame(32'h2000_0000, 16'h0100);
    chk("start_clr_err", 64'(o_err), 64'd0);
    for (int k = 0; k < 4; k++) begin
      serve(0, a, hb);
      chk("f2_prime_addr", 64'(a), 64'(32'h2000_0000 + 32'(k) * 32'h100));
    end
    for (int k = 0; k < 4; k++) pulse_intr();
    chk("ovf_pre_err",  64'(o_err), 64'd0);
    chk("ovf_pre_cred", 64'(dut.credits), 64'd4);
    chk("ovf_req_hold", 64'(o_dma_req), 64'd1);
    pulse_intr();
    chk("ovf_err",  64'(o_err), 64'd1);
    chk("ovf_cred", 64'(dut.credits), 64'd4);
    chk("ovf_addr", 64'(o_dma_addr), 64'h2000_0400);

    // Reset mid-frame at row 200, address wraps past 2^32
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    start_frame(32'hFFFF_0000, 16'h0400);
    for (int k = 0; k < 4; k++) serve(0, a, hb);
    for (int k = 4; k < 200; k++) begin
      pulse_intr();
      serve(0, a, hb);
    end
    pulse_intr();
    wait_req();
    chk("r200_addr", 64'(o_dma_addr), 64'h0002_2000);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("rst_req_drop", 64'(o_dma_req),    64'd0);
    chk("rst_mid_busy", 64'(o_busy),       64'd0);
    chk("rst_mid_done", 64'(o_frame_done), 64'd0);
    repeat (3) tick();
    chk("rst_no_done",  64'(done_cnt),     64'd1);
    chk("rst_mid_cred", 64'(dut.credits),  64'd4);
    start_frame(32'hFFFF_0000, 16'h0400);
    serve(0, a, hb);
    chk("restart_addr", 64'(a), 64'hFFFF_0000);
    i_dma_ack = 1'b1; tick(); i_dma_ack = 1'b0;
    chk("stray_ack_err", 64'(o_err), 64'd1);
    serve(0, a, hb);
    chk("stray_ack_row", 64'(a), 64'hFFFF_0400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
